sigma_delta_pipe: RTL
=====================

SIGMA_DELTA_PIPE -- requirements
Module: sigma_delta_pipe

Interface
REQ-001 Parameters SHALL be: PIX_W, 8, pixel/background/variance width; LANES, 4, pixels per beat; N_AMP, 2, variance amplification factor (1..15); VMIN, 2, variance floor; VMAX, 2**PIX_W-1, variance ceiling; LOG_PERIOD, 0, variance updates every 2**LOG_PERIOD frames; CNT_W, 16, frame counter width.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be (name direction width meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- enable  in  1  1=sigma-delta update, 0=pass-through
- init_frame  in  1  beat loads background from pixel
- sof  in  1  first beat of a frame
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&in_ready
- curr_pixel  in  LANES*PIX_W  current pixels, lane i at [i*PIX_W +: PIX_W]
- background  in  LANES*PIX_W  stored background per lane
- variance  in  LANES*PIX_W  stored variance per lane
- out_valid  out  1  result beat valid
- out_ready  in  1  result consumed when out_valid&out_ready
- background_next  out  LANES*PIX_W  updated background
- variance_next  out  LANES*PIX_W  updated variance
- motion_detected  out  LANES  per-lane motion flag
- frame_cnt  out  CNT_W  current frame index

Function
REQ-004 Two-stage pipeline SHALL be used: S1 registers inputs, delta and update-permit; S2 registers results; latency = 2 cycles from acceptance to out_valid with out_ready=1.
REQ-005 Stage advance SHALL be: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv (combinational, no input-to-in_ready path except through out_ready).
REQ-006 Under backpressure every accepted beat SHALL appear exactly once, in order, with outputs held stable while out_valid&!out_ready.
REQ-007 Per lane, delta SHALL = |curr_pixel - background| (PIX_W bits, unsigned, no wrap).
REQ-008 Background (enable=1, init_frame=0): curr>bg -> bg+1; curr<bg -> bg-1; equal -> bg (never overflows).
REQ-009 Variance, when update permitted and delta!=0: v<N_AMP*delta -> v+1; v>N_AMP*delta -> v-1; else v; N_AMP*delta computed in PIX_W+4 bits, no truncation; delta==0 or not permitted -> v unchanged.
REQ-010 variance_next SHALL then be clamped to [VMIN,VMAX], including when the input variance is already out of range.
REQ-011 motion_detected[i] SHALL = (delta > variance input) when enable=1 and init_frame=0, else 0.
REQ-012 init_frame=1 (any enable): background_next=curr_pixel, variance_next=VMIN, motion=0; frame_cnt still updated per REQ-014.
REQ-013 enable=0, init_frame=0: background_next=background, variance_next=variance (unclamped), motion=0; beats still flow through pipeline.
REQ-014 frame_cnt SHALL increment by 1 on each accepted beat with sof=1, wrapping 2**CNT_W-1 -> 0; that beat and following beats use the new value.
REQ-015 Update permitted iff frame_cnt[LOG_PERIOD-1:0]==0 for the beat (always permitted when LOG_PERIOD=0), sampled at acceptance.
REQ-016 sof without in_valid&in_ready SHALL be ignored.

Reset
REQ-017 rst=1 SHALL immediately clear s1_valid, s2_valid, out_valid, frame_cnt=0, motion_detected=0, background_next=0, variance_next=0; in_ready=1 from the first edge after release.
REQ-018 Reset mid-operation SHALL discard all in-flight beats; no partial beat emerges after release.

Verification (PIX_W=8, LANES=4, N_AMP=2, VMIN=2, VMAX=255, LOG_PERIOD=0 unless noted)
REQ-019 Lane0 bg=100 curr=110 var=5, enable=1 -> 2 cycles later bg_next=101, var_next=6, motion[0]=1; lane1 bg=curr=50 var=7 -> 50, 7, motion=0.
REQ-020 Clamp: bg=10 curr=10 var=1 -> var_next=2; bg=0 curr=200 var=255 -> var_next=255, bg_next=1; init_frame=1 curr=77 -> bg_next=77, var_next=2, motion=0.
REQ-021 Backpressure: 6 back-to-back beats, out_ready=0 cycles 2-4 -> in_ready low while both stages full, all 6 results out once in order, outputs stable while stalled.
REQ-022 LOG_PERIOD=1: beat in frame_cnt=1 with bg=100 curr=110 var=5 -> var_next=5; frame_cnt=2 -> var_next=6; CNT_W=2 sof count 3 -> 0 wrap.
REQ-023 rst asserted with 2 beats in flight -> out_valid=0 same cycle, frame_cnt=0; no stale beat after release.
REQ-024 enable=0, bg=30 curr=200 var=0 -> bg_next=30, var_next=0, motion=0.

Source files
------------

// File: rtl/sigma_delta_pipe.sv
// Two-stage sigma-delta background/variance update pipeline.
// Each beat carries LANES pixels. Stage 1 captures the inputs, the per-lane
// absolute difference and the update permit. Stage 2 registers the updated
// background, the updated variance and the motion flags.
module sigma_delta_pipe #(
    parameter int PIX_W      = 8,
    parameter int LANES      = 4,
    parameter int N_AMP      = 2,
    parameter int VMIN       = 2,
    parameter int VMAX       = 2**PIX_W - 1,
    parameter int LOG_PERIOD = 0,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   init_frame,
    input  logic                   sof,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*PIX_W-1:0] curr_pixel,
    input  logic [LANES*PIX_W-1:0] background,
    input  logic [LANES*PIX_W-1:0] variance,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*PIX_W-1:0] background_next,
    output logic [LANES*PIX_W-1:0] variance_next,
    output logic [LANES-1:0]       motion_detected,
    output logic [CNT_W-1:0]       frame_cnt
);

    // One spare bit so that v+1 at the ceiling can be clamped rather than wrapped.
    localparam int EXT_W = PIX_W + 1;
    // N_AMP <= 15, so N_AMP*delta always fits in four extra bits.
    localparam int AMP_W = PIX_W + 4;

    localparam logic [EXT_W-1:0] VMIN_E      = EXT_W'(VMIN);
    localparam logic [EXT_W-1:0] VMAX_E      = EXT_W'(VMAX);
    localparam logic [AMP_W-1:0] N_AMP_E     = AMP_W'(N_AMP);
    localparam logic [CNT_W-1:0] PERIOD_MASK = CNT_W'((1 << LOG_PERIOD) - 1);

    // |a - b| without wrap, formed through a signed difference.
    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        logic signed [PIX_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d[PIX_W]) begin
            abs_diff = PIX_W'(-d);
        end else begin
            abs_diff = d[PIX_W-1:0];
        end
    endfunction

    // Saturate a widened variance into [VMIN, VMAX].
    function automatic logic [PIX_W-1:0] clamp_var(input logic [EXT_W-1:0] v);
        if (v < VMIN_E) begin
            clamp_var = VMIN_E[PIX_W-1:0];
        end else if (v > VMAX_E) begin
            clamp_var = VMAX_E[PIX_W-1:0];
        end else begin
            clamp_var = v[PIX_W-1:0];
        end
    endfunction

    // Move the background one step toward the current pixel. It moves up only
    // when curr > bg, so bg is below the maximum and cannot overflow.
    function automatic logic [PIX_W-1:0] bg_step(input logic [PIX_W-1:0] b,
                                                 input logic [PIX_W-1:0] c);
        if (c > b) begin
            bg_step = b + PIX_W'(1);
        end else if (c < b) begin
            bg_step = b - PIX_W'(1);
        end else begin
            bg_step = b;
        end
    endfunction

    // Move the variance one step toward N_AMP*delta. The result is widened and
    // left unclamped.
    function automatic logic [EXT_W-1:0] var_step(input logic [PIX_W-1:0] v,
                                                  input logic [PIX_W-1:0] d,
                                                  input logic             permit);
        logic [AMP_W-1:0] amp;
        logic [AMP_W-1:0] v_a;
        amp = AMP_W'(d) * N_AMP_E;
        v_a = AMP_W'(v);
        var_step = {1'b0, v};
        if (permit && (d != '0)) begin
            if (v_a < amp) begin
                var_step = {1'b0, v} + EXT_W'(1);
            end else if (v_a > amp) begin
                var_step = {1'b0, v} - EXT_W'(1);
            end
        end
    endfunction

    logic                   vld_p1;
    logic                   vld_p2;
    logic                   s1_adv;
    logic                   s2_adv;
    logic                   accept;
    logic [CNT_W-1:0]       cnt_beat;
    logic                   permit;
    logic [LANES*PIX_W-1:0] delta_in;

    logic [LANES*PIX_W-1:0] curr_p1;
    logic [LANES*PIX_W-1:0] bg_p1;
    logic [LANES*PIX_W-1:0] var_p1;
    logic [LANES*PIX_W-1:0] delta_p1;
    logic                   permit_p1;
    logic                   enable_p1;
    logic                   init_p1;

    logic [LANES*PIX_W-1:0] bg_calc;
    logic [LANES*PIX_W-1:0] var_calc;
    logic [LANES-1:0]       motion_calc;

    logic [LANES*PIX_W-1:0] bg_p2;
    logic [LANES*PIX_W-1:0] var_p2;
    logic [LANES-1:0]       motion_p2;

    // Handshake, the frame index this beat will use, and the update permit.
    always_comb begin
        s2_adv   = !vld_p2 || out_ready;
        s1_adv   = !vld_p1 || s2_adv;
        in_ready = s1_adv;
        accept   = in_valid && s1_adv;
        cnt_beat = sof ? frame_cnt + CNT_W'(1) : frame_cnt;
        permit   = ((cnt_beat & PERIOD_MASK) == '0);
    end

    // Per-lane absolute difference between the pixel and the background.
    always_comb begin
        delta_in = '0;
        for (int i = 0; i < LANES; i++) begin
            delta_in[i*PIX_W +: PIX_W] = abs_diff(curr_pixel[i*PIX_W +: PIX_W],
                                                  background[i*PIX_W +: PIX_W]);
        end
    end

    // Frame counter: advances on an accepted start-of-frame beat and wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (accept && sof) begin
            frame_cnt <= cnt_beat;
        end
    end

    // ---- stage 1: capture inputs, delta and permit ----
    // Stage 1 occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (s1_adv) begin
            vld_p1 <= in_valid;
        end
    end

    // Stage 1 payload; only meaningful while vld_p1 is set.
    always_ff @(posedge clk) begin
        if (s1_adv) begin
            curr_p1   <= curr_pixel;
            bg_p1     <= background;
            var_p1    <= variance;
            delta_p1  <= delta_in;
            permit_p1 <= permit;
            enable_p1 <= enable;
            init_p1   <= init_frame;
        end
    end

    // Per-lane update selected by mode: init, pass-through or sigma-delta.
    always_comb begin
        bg_calc     = '0;
        var_calc    = '0;
        motion_calc = '0;
        for (int i = 0; i < LANES; i++) begin
            if (init_p1) begin
                bg_calc[i*PIX_W +: PIX_W]  = curr_p1[i*PIX_W +: PIX_W];
                var_calc[i*PIX_W +: PIX_W] = VMIN_E[PIX_W-1:0];
            end else if (!enable_p1) begin
                bg_calc[i*PIX_W +: PIX_W]  = bg_p1[i*PIX_W +: PIX_W];
                var_calc[i*PIX_W +: PIX_W] = var_p1[i*PIX_W +: PIX_W];
            end else begin
                bg_calc[i*PIX_W +: PIX_W]  = bg_step(bg_p1[i*PIX_W +: PIX_W],
                                                     curr_p1[i*PIX_W +: PIX_W]);
                var_calc[i*PIX_W +: PIX_W] = clamp_var(var_step(var_p1[i*PIX_W +: PIX_W],
                                                                delta_p1[i*PIX_W +: PIX_W],
                                                                permit_p1));
                motion_calc[i] = (delta_p1[i*PIX_W +: PIX_W] > var_p1[i*PIX_W +: PIX_W]);
            end
        end
    end

    // ---- stage 2: register results; these drive the outputs directly ----
    // Stage 2 occupancy and results. The results are cleared on reset so that
    // the outputs read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2    <= 1'b0;
            bg_p2     <= '0;
            var_p2    <= '0;
            motion_p2 <= '0;
        end else if (s2_adv) begin
            vld_p2    <= vld_p1;
            bg_p2     <= bg_calc;
            var_p2    <= var_calc;
            motion_p2 <= motion_calc;
        end
    end

    assign out_valid       = vld_p2;
    assign background_next = bg_p2;
    assign variance_next   = var_p2;
    assign motion_detected = motion_p2;

endmodule
